// File: rtl/alu_rs.sv
// alu_rs: reservation station for ALU pipe 1.
// Collapsing age queue (entry 0 oldest, valid entries contiguous from 0),
// up to four enqueues per cycle, operand capture from two result buses,
// oldest-ready single issue per cycle, registered free-entry count.
module alu_rs #(
  parameter int DEPTH  = 6,
  parameter int INFO_W = 107,
  parameter int PREG_W = 7
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              RsFlash,
  input  logic              Inst1Able,
  input  logic [INFO_W-1:0] Inst1Infor,
  input  logic              Inst2Able,
  input  logic [INFO_W-1:0] Inst2Infor,
  input  logic              Inst3Able,
  input  logic [INFO_W-1:0] Inst3Infor,
  input  logic              Inst4Able,
  input  logic [INFO_W-1:0] Inst4Infor,
  output logic [2:0]        RsFreeNum,
  input  logic              Cdb1Able,
  input  logic [PREG_W-1:0] Cdb1Addr,
  input  logic [31:0]       Cdb1Date,
  input  logic              Cdb2Able,
  input  logic [PREG_W-1:0] Cdb2Addr,
  input  logic [31:0]       Cdb2Date,
  input  logic              IssueStall,
  output logic              IssueAble,
  output logic [7:0]        IssueMicOp,
  output logic [31:0]       IssueSrc1,
  output logic [31:0]       IssueSrc2,
  output logic              IssueWriteAble,
  output logic [31:0]       IssueWriteAddr
);

  // Field layout matches the dispatch info word bit for bit.
  typedef struct packed {
    logic [7:0]  op;
    logic        s1a;
    logic [31:0] s1d;
    logic        s2a;
    logic [31:0] s2d;
    logic        wa;
    logic [31:0] waddr;
  } entry_t;

  typedef struct packed {
    logic              able;
    logic [PREG_W-1:0] tag;
    logic [31:0]       data;
  } cdb_t;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  entry_t      ent_q [DEPTH];
  entry_t      ent_d [DEPTH];
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  free_q, free_d;
  logic        issue_able_q, issue_able_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic        wa_q, wa_d;
  logic [31:0] waddr_q, waddr_d;

  cdb_t        cdb1_s, cdb2_s;
  logic        way_v_s [4];
  entry_t      way_e_s [4];
  logic        sel_found_s;
  logic [2:0]  sel_idx_s;
  logic        issue_fire_s;
  logic [2:0]  remain_s;
  logic [2:0]  src_s;
  logic [2:0]  wp_s;

  // Capture one source from the broadcast buses; bus 1 wins a double match.
  function automatic logic [32:0] wake_src(input logic able, input logic [31:0] date,
                                           input cdb_t c1, input cdb_t c2);
    logic [32:0] r;
    if (able) begin
      r = {able, date};
    end else if (c1.able && (date[PREG_W-1:0] == c1.tag)) begin
      r = {1'b1, c1.data};
    end else if (c2.able && (date[PREG_W-1:0] == c2.tag)) begin
      r = {1'b1, c2.data};
    end else begin
      r = {able, date};
    end
    return r;
  endfunction

  // Apply same-cycle wakeup to both sources of an entry.
  function automatic entry_t wake_entry(input entry_t e, input cdb_t c1, input cdb_t c2);
    entry_t r;
    r = e;
    {r.s1a, r.s1d} = wake_src(e.s1a, e.s1d, c1, c2);
    {r.s2a, r.s2d} = wake_src(e.s2a, e.s2d, c1, c2);
    return r;
  endfunction

  assign cdb1_s = {Cdb1Able, Cdb1Addr, Cdb1Date};
  assign cdb2_s = {Cdb2Able, Cdb2Addr, Cdb2Date};

  // Gather the four dispatch ways into indexable arrays.
  always_comb begin
    way_v_s[0] = Inst1Able;
    way_v_s[1] = Inst2Able;
    way_v_s[2] = Inst3Able;
    way_v_s[3] = Inst4Able;
    way_e_s[0] = entry_t'(Inst1Infor);
    way_e_s[1] = entry_t'(Inst2Infor);
    way_e_s[2] = entry_t'(Inst3Infor);
    way_e_s[3] = entry_t'(Inst4Infor);
  end

  // Oldest-ready select over the registered state only.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found_s && (3'(i) < cnt_q) && ent_q[i].s1a && ent_q[i].s2a) begin
        sel_found_s = 1'b1;
        sel_idx_s   = 3'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    issue_fire_s = sel_found_s && !IssueStall;
  end

  // Next queue contents: remove issued entry, collapse, append ways, wake all.
  always_comb begin
    remain_s = cnt_q - {2'b00, issue_fire_s};
    src_s    = 3'd0;
    for (int j = 0; j < DEPTH; j++) begin
      if (issue_fire_s && (3'(j) >= sel_idx_s)) begin
        src_s = 3'(j + 1);
      end else begin
        src_s = 3'(j);
      end
      if ((3'(j) < remain_s) && (src_s < DEPTH_C)) begin
        ent_d[j] = wake_entry(ent_q[src_s], cdb1_s, cdb2_s);
      end else begin
        ent_d[j] = '0;
      end
    end
    // Ways beyond capacity are dropped in way order.
    wp_s = remain_s;
    for (int w = 0; w < 4; w++) begin
      if (way_v_s[w] && (wp_s < DEPTH_C)) begin
        ent_d[wp_s] = wake_entry(way_e_s[w], cdb1_s, cdb2_s);
        wp_s        = wp_s + 3'd1;
      end else begin
        wp_s = wp_s;
      end
    end
    cnt_d = wp_s;
    if (RsFlash) begin
      for (int j = 0; j < DEPTH; j++) begin
        ent_d[j] = '0;
      end
      cnt_d = 3'd0;
    end else begin
      cnt_d = cnt_d;
    end
    free_d = DEPTH_C - cnt_d;
  end

  // Issue register update; data holds when nothing issues.
  always_comb begin
    issue_able_d = 1'b0;
    op_d         = op_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    wa_d         = wa_q;
    waddr_d      = waddr_q;
    if (RsFlash) begin
      issue_able_d = 1'b0;
    end else if (issue_fire_s) begin
      issue_able_d = 1'b1;
      op_d         = ent_q[sel_idx_s].op;
      src1_d       = ent_q[sel_idx_s].s1d;
      src2_d       = ent_q[sel_idx_s].s2d;
      wa_d         = ent_q[sel_idx_s].wa;
      waddr_d      = ent_q[sel_idx_s].waddr;
    end else begin
      issue_able_d = 1'b0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q        <= 3'd0;
      free_q       <= DEPTH_C;
      issue_able_q <= 1'b0;
      op_q         <= 8'd0;
      src1_q       <= 32'd0;
      src2_q       <= 32'd0;
      wa_q         <= 1'b0;
      waddr_q      <= 32'd0;
    end else begin
      ent_q        <= ent_d;
      cnt_q        <= cnt_d;
      free_q       <= free_d;
      issue_able_q <= issue_able_d;
      op_q         <= op_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      wa_q         <= wa_d;
      waddr_q      <= waddr_d;
    end
  end

  assign RsFreeNum      = free_q;
  assign IssueAble      = issue_able_q;
  assign IssueMicOp     = op_q;
  assign IssueSrc1      = src1_q;
  assign IssueSrc2      = src2_q;
  assign IssueWriteAble = wa_q;
  assign IssueWriteAddr = waddr_q;

endmodule
